instr_mem_loader: RTL and testbench

- Writer side of the Hack instruction memory. Receives a byte stream from the serial receiver at boot and writes assembled 16-bit Hack instructions into instruction RAM, starting at a base address.
- Holds the CPU in reset while loading and releases it on completion.
- Sits between the UART receiver and the instruction-memory write port; the CPU fetch port is unaffected.

---
 rtl/hack_loader_pkg.sv | 44 ++++
 rtl/loader_byte_timer.sv | 32 +++
 rtl/instr_mem_loader.sv | 188 ++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hack_loader_pkg.sv
// Shared constants and state encoding for the Hack instruction-memory loader.
// Optional checksum trailer states are used when LOADER_CHECKSUM_EN is defined.
package hack_loader_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned HDR_BYTES = 2;
    localparam int unsigned SUM_BYTES = 2;
    localparam int unsigned LEN_W     = HDR_BYTES * BYTE_W;
    localparam int unsigned SUM_W     = SUM_BYTES * BYTE_W;
    localparam int unsigned STATE_W   = 4;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_LEN_HI  = 4'd1;
    localparam state_t S_LEN_LO  = 4'd2;
    localparam state_t S_DATA_HI = 4'd3;
    localparam state_t S_DATA_LO = 4'd4;
    localparam state_t S_WRITE   = 4'd5;
    localparam state_t S_DONE    = 4'd6;
    localparam state_t S_ERROR   = 4'd7;
    localparam state_t S_SUM_HI  = 4'd8;
    localparam state_t S_SUM_LO  = 4'd9;

    // States in which a byte may be consumed from the receiver.
    function automatic logic is_rx_state(input state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) ||
               (s == S_DATA_LO) || (s == S_SUM_HI) || (s == S_SUM_LO);
    endfunction

    // Mid-load states where an idle gap between bytes counts toward timeout.
    function automatic logic is_timed_state(input state_t s);
        return (s == S_LEN_LO) || (s == S_DATA_HI) || (s == S_DATA_LO) ||
               (s == S_SUM_HI) || (s == S_SUM_LO);
    endfunction

    // States from which a start pulse launches a new load.
    function automatic logic is_rest_state(input state_t s);
        return (s == S_IDLE) || (s == S_DONE) || (s == S_ERROR);
    endfunction

endpackage

// File: rtl/loader_byte_timer.sv
// Idle-gap counter between received bytes; expired_c fires on the cycle whose
// edge would complete TIMEOUT_CYCLES idle cycles (0 disables it).
module loader_byte_timer
    import hack_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = 32;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired_c = (TIMEOUT_CYCLES != 0) && enable &&
                       (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: assembles big-endian words from the UART byte stream into Hack
// instruction RAM while holding the CPU in reset. Macro: LOADER_CHECKSUM_EN.
module instr_mem_loader
    import hack_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int unsigned       MAX_WORDS      = 4001,
    parameter int unsigned       TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t state;
    state_t state_nx;

    logic [BYTE_W-1:0] len_hi;
    logic [BYTE_W-1:0] data_hi;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  word_cnt;

    logic              accept_c;
    logic              launch_c;
    logic              last_word_c;
    logic              timeout_c;
    logic [LEN_W-1:0]  len_nx_c;
    state_t            after_last_c;

`ifdef LOADER_CHECKSUM_EN
    logic [SUM_W-1:0]  sum;
    logic [BYTE_W-1:0] sum_hi;
    assign after_last_c = S_SUM_HI;
`else
    assign after_last_c = S_DONE;
`endif

    assign accept_c    = rx_valid & rx_ready;
    assign launch_c    = start & is_rest_state(state);
    assign len_nx_c    = {len_hi, rx_data};
    assign last_word_c = (word_cnt + LEN_W'(1)) == len;

    loader_byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (~is_timed_state(state) | accept_c),
        .enable   (is_timed_state(state) & ~accept_c),
        .expired_c(timeout_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_nx = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept_c) state_nx = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept_c) begin
                    if (len_nx_c == '0) begin
                        state_nx = after_last_c;
                    end else if (32'(len_nx_c) > MAX_WORDS) begin
                        state_nx = S_ERROR;
                    end else begin
                        state_nx = S_DATA_HI;
                    end
                end else if (timeout_c) begin
                    state_nx = S_ERROR;
                end
            end
            S_DATA_HI: begin
                if (accept_c)       state_nx = S_DATA_LO;
                else if (timeout_c) state_nx = S_ERROR;
            end
            S_DATA_LO: begin
                if (accept_c)       state_nx = S_WRITE;
                else if (timeout_c) state_nx = S_ERROR;
            end
            S_WRITE: begin
                state_nx = last_word_c ? after_last_c : S_DATA_HI;
            end
`ifdef LOADER_CHECKSUM_EN
            S_SUM_HI: begin
                if (accept_c)       state_nx = S_SUM_LO;
                else if (timeout_c) state_nx = S_ERROR;
            end
            S_SUM_LO: begin
                if (accept_c)       state_nx = ({sum_hi, rx_data} == sum) ? S_DONE : S_ERROR;
                else if (timeout_c) state_nx = S_ERROR;
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    // Byte capture, address/word counters and the write-port payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_hi    <= '0;
            data_hi   <= '0;
            len       <= '0;
            addr      <= '0;
            word_cnt  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum       <= '0;
            sum_hi    <= '0;
`endif
        end else if (launch_c) begin
            addr     <= BASE_ADDR;
            word_cnt <= '0;
        end else begin
            case (state)
                S_LEN_HI: if (accept_c) len_hi <= rx_data;
                S_LEN_LO: begin
                    if (accept_c) begin
                        len <= len_nx_c;
`ifdef LOADER_CHECKSUM_EN
                        sum <= SUM_W'(len_nx_c);
`endif
                    end
                end
                S_DATA_HI: if (accept_c) data_hi <= rx_data;
                S_DATA_LO: begin
                    if (accept_c) begin
                        mem_addr  <= addr;
                        mem_wdata <= {data_hi, rx_data};
                    end
                end
                S_WRITE: begin
                    addr     <= addr + ADDR_W'(1);
                    word_cnt <= word_cnt + LEN_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    sum      <= sum + SUM_W'(mem_wdata);
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                S_SUM_HI: if (accept_c) sum_hi <= rx_data;
`endif
                default: ;
            endcase
        end
    end

    // Status outputs registered from the next state so they track it exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ready <= 1'b0;
            mem_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            rx_ready <= is_rx_state(state_nx);
            mem_we   <= (state_nx == S_WRITE);
            busy     <= ~is_rest_state(state_nx);
            done     <= (state_nx == S_DONE);
            error    <= (state_nx == S_ERROR);
            cpu_hold <= (state_nx != S_DONE);
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader (TIMEOUT_CYCLES=50, BASE_ADDR=0).
// Checksum cases are compiled in when LOADER_CHECKSUM_EN is defined.
module tb_instr_mem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];

    instr_mem_loader #(
        .BASE_ADDR     (16'h0000),
        .MAX_WORDS     (4001),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write-port pulse away from the active edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 20) begin
            step();
            n++;
        end
        if (!rx_ready) check_eq("rx_ready_wait", 32'(rx_ready), 32'd1);
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic send_trailer(input logic [15:0] s);
`ifdef LOADER_CHECKSUM_EN
        send_word(s);
`else
        if (s == 16'hFFFF) step();
`endif
    endtask

    task automatic wait_status(input string tag);
        int n;
        n = 0;
        while (!(done || error) && n < 20) begin
            step();
            n++;
        end
        check_eq({tag, "_wait"}, 32'(done | error), 32'd1);
    endtask

    initial begin
        int          base;
        int          first;
        logic [15:0] exp_w[3];
        exp_w = '{16'h1234, 16'hABCD, 16'h0001};

        reset    = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) step();
        check_eq("reset_outputs", 32'({cpu_hold, busy, done, error, rx_ready, mem_we}), 32'b100000);
        check_eq("reset_addr", 32'(mem_addr), 32'h0);
        reset = 1'b0;
        step();

        // N=3 load, start coinciding with an offered byte.
        base     = wr_addr_q.size();
        rx_data  = 8'h00;
        rx_valid = 1'b1;
        pulse_start();
        check_eq("start_state", 32'({busy, rx_ready, cpu_hold, done}), 32'b1110);
        send_byte(8'h00);
        send_byte(8'h03);
        send_word(16'h1234);
        send_word(16'hABCD);
        send_word(16'h0001);
        check_eq("we_latency", 32'(mem_we), 32'd1);
        check_eq("write_rx_ready", 32'(rx_ready), 32'd0);
        check_eq("write_addr", 32'(mem_addr), 32'd2);
        send_trailer(16'hBE05);
        wait_status("n3");
        check_eq("n3_status", 32'({done, error, busy, cpu_hold}), 32'b1000);
        check_eq("n3_count", 32'(wr_addr_q.size() - base), 32'd3);
        if (wr_addr_q.size() >= base + 3) begin
            for (int i = 0; i < 3; i++) begin
                check_eq($sformatf("n3_addr%0d", i), 32'(wr_addr_q[base+i]), 32'(i));
                check_eq($sformatf("n3_data%0d", i), 32'(wr_data_q[base+i]), 32'(exp_w[i]));
            end
        end
        step();
        check_eq("hold_addr", 32'(mem_addr), 32'd2);
        check_eq("hold_data", 32'(mem_wdata), 32'h0001);
        check_eq("hold_we", 32'(mem_we), 32'd0);

        // N=0: straight to DONE, no writes.
        base = wr_addr_q.size();
        pulse_start();
        check_eq("n0_start_clears_done", 32'({done, busy, cpu_hold}), 32'b011);
        send_word(16'h0000);
        send_trailer(16'h0000);
        check_eq("n0_done", 32'({done, error, busy, cpu_hold}), 32'b1000);
        check_eq("n0_writes", 32'(wr_addr_q.size() - base), 32'd0);

        // N=4002 exceeds MAX_WORDS.
        base = wr_addr_q.size();
        pulse_start();
        send_word(16'd4002);
        check_eq("big_error", 32'({error, cpu_hold, busy, done, rx_ready}), 32'b11000);
        step();
        check_eq("big_writes", 32'(wr_addr_q.size() - base), 32'd0);

        // Stall after a WORD_HI byte: error exactly 50 cycles later.
        base = wr_addr_q.size();
        pulse_start();
        check_eq("restart_clears_error", 32'({error, busy}), 32'b01);
        send_word(16'h0002);
        send_word(16'h1122);
        send_byte(8'h33);
        first = 0;
        for (int c = 1; c <= 100 && first == 0; c++) begin
            step();
            if (error) first = c;
        end
        check_eq("timeout_cycles", 32'(first), 32'd50);
        check_eq("timeout_hold", 32'({cpu_hold, busy, done}), 32'b100);
        check_eq("timeout_writes", 32'(wr_addr_q.size() - base), 32'd1);
        pulse_start();
        check_eq("restart_after_timeout", 32'({error, busy}), 32'b01);

        // Async reset during DATA_LO of the second word.
        send_word(16'h0003);
        send_word(16'h000A);
        send_byte(8'h00);
        reset = 1'b1;
        #1;
        check_eq("midreset_outputs", 32'({mem_we, cpu_hold, busy, rx_ready, done, error}), 32'b010000);
        check_eq("midreset_wdata", 32'(mem_wdata), 32'h0);
        step();
        reset = 1'b0;
        step();
        base = wr_addr_q.size();
        pulse_start();
        send_word(16'h0001);
        send_word(16'hBEEF);
        send_trailer(16'hBEF0);
        wait_status("reload");
        check_eq("reload_done", 32'({done, error}), 32'b10);
        check_eq("reload_count", 32'(wr_addr_q.size() - base), 32'd1);
        if (wr_addr_q.size() > base) begin
            check_eq("reload_addr", 32'(wr_addr_q[base]), 32'h0);
            check_eq("reload_data", 32'(wr_data_q[base]), 32'hBEEF);
        end

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch, word written either way.
        base = wr_addr_q.size();
        pulse_start();
        send_word(16'h0001);
        send_word(16'h0005);
        send_word(16'h0006);
        check_eq("sum_ok", 32'({done, error}), 32'b10);
        pulse_start();
        send_word(16'h0001);
        send_word(16'h0005);
        send_word(16'h0007);
        check_eq("sum_bad", 32'({done, error, cpu_hold}), 32'b011);
        step();
        check_eq("sum_writes", 32'(wr_addr_q.size() - base), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
